// File: rtl/std_sdiv_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : std_sdiv_pipe
//  Purpose  : Multi-cycle signed divider (restoring, one bit per cycle) with
//             go/done handshake; quotient truncates toward zero, remainder
//             takes the sign of the dividend.
//  Revision : 1.0  initial release
// ============================================================================
module std_sdiv_pipe #(
   parameter int width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [width-1:0] left,
   input  logic [width-1:0] right,
   output logic [width-1:0] out_quotient,
   output logic [width-1:0] out_remainder,
   output logic             done
);

   localparam int CNT_W = $clog2(width + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [width:0]     r_dvd;
   logic [width:0]     r_dvs;
   logic [width-1:0]   r_rem;
   logic [width-1:0]   r_left;
   logic               r_sign_q;
   logic               r_sign_r;
   logic               r_div0;
   logic [CNT_W-1:0]   r_cnt;
   logic [width-1:0]   r_quot_out;
   logic [width-1:0]   r_rem_out;

   logic [width:0]     w_abs_left;
   logic [width:0]     w_abs_right;
   logic [width:0]     w_shift;
   logic [width:0]     w_diff;
   logic               w_fit;
   logic [width-1:0]   w_q_fix;
   logic [width-1:0]   w_r_fix;
   logic               w_unused_bits;

   // Magnitudes carry one extra bit so that |-2^(width-1)| is representable.
   assign w_abs_left  = left[width-1]
                      ? ({(width+1){1'b0}} - {left[width-1], left})
                      : {1'b0, left};
   assign w_abs_right = right[width-1]
                      ? ({(width+1){1'b0}} - {right[width-1], right})
                      : {1'b0, right};

   // The partial remainder is always below |right| <= 2^(width-1), so width
   // bits hold it; the dividend shifts out MSB first as quotient bits shift in.
   assign w_shift = {r_rem, r_dvd[width-1]};
   assign w_fit   = (w_shift >= r_dvs);
   assign w_diff  = w_shift - r_dvs;

   assign w_q_fix = r_div0   ? {width{1'b0}}
                  : r_sign_q ? ({width{1'b0}} - r_dvd[width-1:0])
                  :            r_dvd[width-1:0];
   assign w_r_fix = r_div0   ? r_left
                  : r_sign_r ? ({width{1'b0}} - r_rem)
                  :            r_rem;

   assign w_unused_bits = ^{r_dvd[width], w_diff[width]};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (go) w_state_nxt = S_CALC;
         S_CALC: begin
            if (!go)                       w_state_nxt = S_IDLE;
            else if (r_cnt == CNT_W'(1))   w_state_nxt = S_FIX;
         end
         S_FIX:  w_state_nxt = go ? S_DONE : S_IDLE;
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_rem      <= '0;
         r_left     <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_div0     <= 1'b0;
         r_cnt      <= '0;
         r_quot_out <= '0;
         r_rem_out  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (go) begin
                  r_dvd    <= w_abs_left;
                  r_dvs    <= w_abs_right;
                  r_rem    <= '0;
                  r_left   <= left;
                  r_sign_q <= left[width-1] ^ right[width-1];
                  r_sign_r <= left[width-1];
                  r_div0   <= (right == {width{1'b0}});
                  r_cnt    <= CNT_W'(width);
               end
            end
            S_CALC: begin
               if (go) begin
                  r_rem <= w_fit ? w_diff[width-1:0] : w_shift[width-1:0];
                  r_dvd <= {r_dvd[width-1:0], w_fit};
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_FIX: begin
               if (go) begin
                  r_quot_out <= w_q_fix;
                  r_rem_out  <= w_r_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_quotient  = r_quot_out;
   assign out_remainder = r_rem_out;
   assign done          = (r_state == S_DONE);

endmodule
`default_nettype wire
